uart_msg_sequencer: RTL

Sequences a fixed ASCII message ("Hello World!\r\n", 14 bytes) into the byte-serial UART transmitter, one byte per tx_start/tx_done_tick handshake. It supports a single-shot send on a start pulse and free-running repeat with a programmable inter-message gap. A watchdog aborts the message if the transmitter never acknowledges a byte. It sits between top-level control (buttons/LEDs) and the UART transmitter.

---
 rtl/uart_msg_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_msg_sequencer.sv
// uart_msg_sequencer: feeds a fixed ASCII message to a byte-serial UART
// transmitter, one byte per tx_start / tx_done_tick handshake. It supports a
// single-shot send, a free-running repeat mode with an idle gap between
// messages, and a per-byte watchdog that aborts a stalled message.
module uart_msg_sequencer #(
  parameter int unsigned MSG_LEN        = 14,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,          // asynchronous, active low
  input  logic       start,
  input  logic       repeat_en,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       msg_done,
  output logic       timeout_err
);

  localparam int unsigned IDX_W  = (MSG_LEN > 1)        ? $clog2(MSG_LEN)        : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1)     ? $clog2(GAP_CYCLES)     : 1;
  localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MSG_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Message ROM: "Hello World!\r\n"
  function automatic logic [7:0] rom_byte(input logic [7:0] idx);
    logic [7:0] b;
    case (idx)
      8'd0:    b = 8'h48;
      8'd1:    b = 8'h65;
      8'd2:    b = 8'h6C;
      8'd3:    b = 8'h6C;
      8'd4:    b = 8'h6F;
      8'd5:    b = 8'h20;
      8'd6:    b = 8'h57;
      8'd7:    b = 8'h6F;
      8'd8:    b = 8'h72;
      8'd9:    b = 8'h6C;
      8'd10:   b = 8'h64;
      8'd11:   b = 8'h21;
      8'd12:   b = 8'h0D;
      8'd13:   b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_e              state_q,       state_d;
  logic [IDX_W-1:0]    byte_idx_q,    byte_idx_d;
  logic [WDOG_W-1:0]   wdog_q,        wdog_d;
  logic [GAP_W-1:0]    gap_q,         gap_d;
  logic                tx_start_q,    tx_start_d;
  logic [7:0]          data_out_q,    data_out_d;
  logic                busy_q,        busy_d;
  logic                msg_done_q,    msg_done_d;
  logic                timeout_err_q, timeout_err_d;

  // Next-state and output decode; tx_start/data_out are loaded on the edge
  // that enters SEND so the byte is valid for the whole tx_start cycle.
  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    wdog_d        = wdog_q;
    gap_d         = gap_q;
    tx_start_d    = 1'b0;
    data_out_d    = data_out_q;
    msg_done_d    = 1'b0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start || repeat_en) begin
          if (start) begin
            timeout_err_d = 1'b0;
          end else begin
            timeout_err_d = timeout_err_q;
          end
          byte_idx_d = {IDX_W{1'b0}};
          state_d    = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        wdog_d  = {WDOG_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // An ack on the expiry cycle takes priority over the watchdog.
        if (tx_done_tick) begin
          wdog_d = {WDOG_W{1'b0}};
          if (byte_idx_q == LAST_IDX) begin
            msg_done_d = 1'b1;
            byte_idx_d = {IDX_W{1'b0}};
            gap_d      = {GAP_W{1'b0}};
            state_d    = repeat_en ? ST_GAP : ST_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
            state_d    = ST_SEND;
          end
        end else if (wdog_q == WDOG_LAST) begin
          timeout_err_d = 1'b1;
          byte_idx_d    = {IDX_W{1'b0}};
          wdog_d        = {WDOG_W{1'b0}};
          state_d       = ST_IDLE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      ST_GAP: begin
        if (!repeat_en) begin
          state_d = ST_IDLE;
        end else if (gap_q == GAP_LAST) begin
          gap_d      = {GAP_W{1'b0}};
          byte_idx_d = {IDX_W{1'b0}};
          state_d    = ST_SEND;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_SEND) begin
      tx_start_d = 1'b1;
      data_out_d = rom_byte(8'(byte_idx_d));
    end else begin
      tx_start_d = 1'b0;
      data_out_d = data_out_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      byte_idx_q    <= {IDX_W{1'b0}};
      wdog_q        <= {WDOG_W{1'b0}};
      gap_q         <= {GAP_W{1'b0}};
      tx_start_q    <= 1'b0;
      data_out_q    <= 8'h00;
      busy_q        <= 1'b0;
      msg_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      wdog_q        <= wdog_d;
      gap_q         <= gap_d;
      tx_start_q    <= tx_start_d;
      data_out_q    <= data_out_d;
      busy_q        <= busy_d;
      msg_done_q    <= msg_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign data_out    = data_out_q;
  assign busy        = busy_q;
  assign msg_done    = msg_done_q;
  assign timeout_err = timeout_err_q;

endmodule
